// File: rtl/seg7_scan_driver_if.sv
// Display-image bus between the switch-entry register and the 7-segment scan driver.
// The scan driver is the slave; it also returns the board-level AN/SEG outputs.
interface seg7_scan_driver_if;
  logic [31:0] data_in;
  logic [7:0]  mask_in;
  logic        load;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        frame_done;
  logic        pending;

  modport master (
    output data_in, mask_in, load,
    input  AN, SEG, frame_done, pending
  );

  modport slave (
    input  data_in, mask_in, load,
    output AN, SEG, frame_done, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Double-buffered, time-multiplexed driver for eight common-anode 7-segment digits,
// with an all-dark blanking gap ahead of every digit to suppress ghosting.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   act_data_q, act_data_d;
  logic [7:0]    act_mask_q, act_mask_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [7:0]    pend_mask_q, pend_mask_d;
  logic          pending_q, pending_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;
  logic          boundary;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_mask_q   <= 8'hFF;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_mask_q   <= act_mask_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    act_data_d   = act_data_q;
    act_mask_d   = act_mask_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;
    an_d         = 8'hFF;
    seg_d        = 7'h7F;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 3'd1;
          boundary = (idx_q == 3'd7);
        end
      end
    endcase

    if (bus.load) begin
      pend_data_d = bus.data_in;
      pend_mask_d = bus.mask_in;
      pending_d   = 1'b1;
    end

    // A load landing on the boundary edge bypasses the pending buffer entirely.
    if (boundary) begin
      frame_done_d = 1'b1;
      pending_d    = 1'b0;
      if (bus.load) begin
        act_data_d = bus.data_in;
        act_mask_d = bus.mask_in;
      end else if (pending_q) begin
        act_data_d = pend_data_q;
        act_mask_d = pend_mask_q;
      end
    end

    // Outputs track the next state so they switch on the same edge as the FSM.
    if (state_d == ST_SHOW && !act_mask_q[idx_d]) begin
      an_d  = ~(8'b1 << idx_d);
      seg_d = glyph(act_data_q[{idx_d, 2'b00} +: 4]);
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: every cycle is compared with a frame/digit/phase model
// derived from the cycle count since reset release and the history of loads.
module tb_seg7_scan_driver;

  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int DP    = SD + BC;
  localparam int FRAME = 8 * DP;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk;
  logic rst_n;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // n = index of the clock edge (counted from reset release) that sampled the load
  typedef struct {
    int          n;
    logic [31:0] d;
    logic [7:0]  m;
  } load_t;

  load_t      loads[$];
  int         t;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ea;
  logic [6:0] es;
  logic       ef, ep;

  // Image of frame f = most recent load sampled no later than the frame's first edge.
  function automatic void exp_at(input int tc, output logic [7:0] an, output logic [6:0] seg,
                                 output logic fd, output logic pd);
    int f, pos, dig, last;
    logic [31:0] d;
    logic [7:0]  m;
    f = tc / FRAME; pos = tc % FRAME; dig = pos / DP;
    d = 32'h0; m = 8'hFF; last = -1;
    foreach (loads[k]) begin
      if (loads[k].n <= f * FRAME) begin d = loads[k].d; m = loads[k].m; end
      if (loads[k].n <= tc) last = loads[k].n;
    end
    an = 8'hFF; seg = 7'h7F;
    if ((pos % DP) >= BC && !m[dig]) begin
      an  = ~(8'h01 << dig);
      seg = GLYPH[d[4*dig +: 4]];
    end
    fd = (tc > 0) && (pos == 0);
    pd = (last > f * FRAME);
  endfunction

  task automatic advance(input bit ld, input logic [31:0] d, input logic [7:0] m);
    bus.load    = ld;
    bus.data_in = ld ? d : $urandom();
    bus.mask_in = ld ? m : 8'($urandom());
    if (ld) begin
      loads.push_back('{t + 1, d, m});
      $display("load t=%0d data=%h mask=%h", t, d, m);
    end
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    t++;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.AN !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", bus.AN); end
    checks++;
    if (bus.SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want 1111111", bus.SEG); end
    checks++;
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
    checks++;
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", bus.pending); end
    rst_n = 1'b1;
    t = 0;
    loads.delete();
    while (t < 3 * FRAME) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL idle t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      advance(1'b0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_full_image();
    int s  = t;
    int lt = t + int'($urandom_range(0, 45));
    while (t < s + 2 * FRAME) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL full_image t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      advance(t == lt, 32'h76543210, 8'h00);
    end
  endtask

  task automatic test_partial_mask();
    int s  = t;
    int lt = t + int'($urandom_range(0, 45));
    while (t < s + 2 * FRAME) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL partial_mask t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      advance(t == lt, 32'hFEDCBA98, 8'hF0);
    end
  endtask

  task automatic test_back_to_back();
    int s   = t;
    int lt1 = t + int'($urandom_range(0, 20));
    int lt2 = lt1 + 1 + int'($urandom_range(0, 24));
    while (t < s + 2 * FRAME) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL back_to_back t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      if (t >= s + FRAME && bus.SEG === 7'b1111001) begin
        errors++;
        $display("FAIL back_to_back_stale t=%0d SEG %b want not 1111001", t, bus.SEG);
      end
      advance(t == lt1 || t == lt2, (t == lt1) ? 32'h11111111 : 32'h22222222, 8'h00);
    end
  endtask

  task automatic test_boundary_load();
    int s = t;
    while (t < s + 2 * FRAME) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL boundary_load t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      advance(t == s + FRAME - 1, 32'hAAAAAAAA, 8'h00);
    end
  endtask

  task automatic test_random();
    int s = t;
    while (t < s + 4 * FRAME) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL random t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      advance($urandom_range(0, 15) == 0, $urandom(), 8'($urandom()));
    end
  endtask

  task automatic test_mid_reset();
    int s = t;
    while (t <= s + FRAME + 3 * DP + BC) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL pre_reset t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      if (t == s + FRAME + 3 * DP + BC) break;
      advance(t == s + 5 || t == s + FRAME + 3, (t == s + 5) ? 32'h89ABCDEF : 32'h13572468, 8'h00);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.AN !== 8'hFF || bus.SEG !== 7'h7F || bus.pending !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset AN %h want ff SEG %b want 1111111 pend %b want 0 fd %b want 0",
               bus.AN, bus.SEG, bus.pending, bus.frame_done);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    loads.delete();
    while (t < 2 * FRAME + 1) begin
      exp_at(t, ea, es, ef, ep);
      checks++;
      if (bus.AN !== ea || bus.SEG !== es || bus.frame_done !== ef || bus.pending !== ep) begin
        errors++;
        $display("FAIL post_reset t=%0d AN %h want %h SEG %b want %b fd %b want %b pend %b want %b",
                 t, bus.AN, ea, bus.SEG, es, bus.frame_done, ef, bus.pending, ep);
      end
      advance(1'b0, 32'h0, 8'h0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 32'h0;
    bus.mask_in = 8'h0;
    t           = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_full_image();
    test_partial_mask();
    test_back_to_back();
    test_boundary_load();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the switch-entry shift register (32-bit nibble register plus 8-bit digit-enable mask) in the lab top level.
- Double-buffers the display image and time-multiplexes it onto the board's eight common-anode 7-segment digits.
- Inserts a blanking gap between digits to suppress ghosting.
- Drives the top-level AN and SEG outputs directly.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is lit (SHOW phase); must be >= 1.
- BLANK_CYCLES, 16, clk cycles all anodes are off before each digit (BLANK phase); must be >= 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  32  display image; digit i shows nibble data_in[4i+3:4i]; digit 0 is rightmost (AN[0]).
- mask_in  input  8  per-digit blank mask; bit i = 1 means digit i is dark, 0 means digit i is lit.
- load  input  1  single-cycle strobe; captures data_in/mask_in into the pending buffer.
- AN  output  8  anode enables, active low, registered.
- SEG  output  7  segments {g,f,e,d,c,b,a} = SEG[6:0], active low, registered.
- frame_done  output  1  one-cycle pulse at each frame boundary.
- pending  output  1  high while a loaded image is waiting to be applied.

Behaviour:
- Reset (async, rst_n=0):
  - AN=8'hFF, SEG=7'h7F, frame_done=0, pending=0.
  - Active data=0, active mask=8'hFF (all dark).
  - Pending buffer=0, digit index=0, state=BLANK, phase counter=0.
- Reset release: operation starts with BLANK of digit 0. No frame_done pulse on the first frame start after reset.
- FSM, two states:
  - BLANK: AN=8'hFF, SEG=7'h7F for BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: lasts SCAN_DIV cycles, then go to BLANK with index+1 (mod 8).
  - Digit period = BLANK_CYCLES+SCAN_DIV; frame = 8 digit periods.
- SHOW outputs for index i:
  - If active mask[i]=0: AN = all ones except bit i = 0; SEG = hex glyph of active nibble i.
  - If active mask[i]=1: AN=8'hFF, SEG=7'h7F.
- Glyphs (SEG[6:0], active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Outputs are registered: AN/SEG change on the same edge as the state/index change, with no combinational path from inputs.
- load:
  - load=1 writes data_in/mask_in into the pending buffer and sets pending=1.
  - Repeated loads before a boundary overwrite; last wins.
- Frame boundary: the edge that leaves SHOW of index 7. On that edge:
  - Index wraps to 0, state goes to BLANK, frame_done=1 for exactly that one following cycle.
  - If pending=1, the pending buffer is copied to the active registers and pending clears.
- load on the boundary cycle: the load data itself is copied straight to active, and pending stays 0.
- Active image never changes mid-frame; a displayed frame is never torn.
- Reset mid-operation: immediate return to reset values; any pending image is discarded.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2, digit period 6, frame 48 cycles):
- Reset, no load -> AN=8'hFF and SEG=7'h7F for 3 full frames; frame_done pulses every 48 cycles starting at cycle 48 after release; pending=0.
- load data_in=32'h76543210, mask_in=8'h00 in frame 0 -> pending=1 until boundary. Then each digit period: 2 cycles AN=FF, then 4 cycles AN=~(1<<i) with SEG=glyph(i) (digit 0: 1000000, digit 7: 1111000).
- load 32'hFEDCBA98, mask 8'hF0 -> digits 0..3 show 8,9,A,b. During SHOW of digits 4..7, AN stays 8'hFF and SEG 7'h7F.
- Two loads in one frame (first 32'h11111111, then 32'h22222222, mask 0) -> next frame shows all "2" (0100100); "1" never appears.
- load asserted exactly on the boundary cycle with 32'hAAAAAAAA -> the frame starting next shows "A" (0001000) on every digit; pending never rises.
- rst_n pulsed low mid-SHOW of digit 3 with pending=1 -> AN=8'hFF, SEG=7'h7F asynchronously; pending=0; after release all digits dark and the scan restarts at digit 0.
